// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmitter arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_arb_pkg;

  localparam int MAX_REQ = 8;
  localparam int BYTE_W  = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: one-hot winner = first set request at or after ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; caller decides when to register the winner.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  winner,
  output logic          any
);

  logic [N-1:0] rot;
  logic [N-1:0] low;

  // Rotate so req[ptr] lands at bit 0, isolate the lowest set bit, rotate back.
  always_comb begin
    rot    = N'({req, req} >> ptr);
    low    = rot & (~rot + N'(1));
    winner = N'(({low, low} << ptr) >> N);
    any    = |req;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin sharing of one UART transmitter among NUM_REQ byte streams.
// Latency: grant 1 cycle after a request is seen idle; tx_start 1 cycle after byte accept.
// Backpressure: req_ready only for the owner in SEND; no grant while tx_busy. Lock timeout: UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [BYTE_W*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      tx_start,
  output logic [BYTE_W-1:0]         tx_data,
  input  logic                      tx_busy,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      active
);

  localparam int PW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > MAX_REQ || TIMEOUT < 1) begin : g_bad_cfg
    $error("uart_tx_arbiter: NUM_REQ must be 2..MAX_REQ and TIMEOUT at least 1");
  end

  arb_state_t          state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [PW-1:0]       rr_ptr_q, rr_ptr_d;
  logic                last_q, last_d;
  logic                tx_start_q, tx_start_d;
  logic [BYTE_W-1:0]   tx_data_q, tx_data_d;

  logic [NUM_REQ-1:0]  pick_win;
  logic                pick_any;
  logic                own_valid;
  logic                own_last;
  logic [BYTE_W-1:0]   own_data;
  logic [PW-1:0]       own_next;

  rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick (
    .req    (req_valid),
    .ptr    (rr_ptr_q),
    .winner (pick_win),
    .any    (pick_any)
  );

  assign own_valid = |(grant_q & req_valid);

  // Select the owner's byte, last flag and the pointer value that follows it.
  always_comb begin
    own_data = '0;
    own_last = 1'b0;
    own_next = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) begin
        own_data = req_data[BYTE_W*i +: BYTE_W];
        own_last = req_last[i];
        own_next = PW'((i + 1) % NUM_REQ);
      end
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] idle_cnt_q;
  logic          tmo_hit;

  // Count stalled SEND cycles; cleared outside SEND so every entry restarts it, saturates at TIMEOUT.
  always_ff @(posedge clk) begin
    if (rst || state_q != SEND) begin
      idle_cnt_q <= '0;
    end else if (!own_valid && idle_cnt_q != CW'(TIMEOUT)) begin
      idle_cnt_q <= idle_cnt_q + CW'(1);
    end
  end

  assign tmo_hit = !own_valid && (idle_cnt_q == CW'(TIMEOUT - 1));
`endif

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      last_q     <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      last_q     <= last_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
    end
  end

  // Next-state and handshake logic; the grant stays locked until the packet's last byte has gone out.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    last_d     = last_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    req_ready  = '0;
    case (state_q)
      IDLE: begin
        if (pick_any && !tx_busy) begin
          grant_d = pick_win;
          state_d = SEND;
        end
      end
      SEND: begin
        if (!rst) req_ready = grant_q & req_valid;
        if (own_valid) begin
          tx_start_d = 1'b1;
          tx_data_d  = own_data;
          last_d     = own_last;
          state_d    = WAIT_BUSY;
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (tmo_hit) begin
          grant_d  = '0;
          rr_ptr_d = own_next;
          state_d  = IDLE;
        end
`endif
      end
      WAIT_BUSY: begin
        if (tx_busy) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          if (last_q) begin
            grant_d  = '0;
            rr_ptr_d = own_next;
            state_d  = IDLE;
          end else begin
            state_d = SEND;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign grant    = grant_q;
  assign active   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with a transaction-level reference model.
// Latency: n/a.
// Backpressure: bench transmitter raises tx_busy the cycle after tx_start.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ = 4;
  localparam int TIMEOUT = 255;
`ifdef UART_ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NUM_REQ-1:0]   req_valid = '0;
  logic [8*NUM_REQ-1:0] req_data = '0;
  logic [NUM_REQ-1:0]   req_last = '0;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_start;
  logic [7:0]           tx_data;
  logic                 tx_busy = 1'b0;
  logic [NUM_REQ-1:0]   grant;
  logic                 active;

  int checks = 0;
  int failures = 0;

  // bench transmitter and traffic control
  bit                 xmit_en = 1'b1;
  bit                 rand_en = 1'b0;
  bit                 launch_seen = 1'b0;
  int                 busy_len = 160;
  int                 busy_left = 0;
  logic [NUM_REQ-1:0] acc = '0;

  // reference model: who owns the transmitter and where its current byte is
  bit         m_on = 1'b0;
  int         m_owner = -1;
  int         m_ptr = 0;
  bit         m_open = 1'b0;   // owner may hand over a byte now
  int         m_phase = 0;     // 0 nothing in flight, 1 launched, 2 transmitter running
  int         m_idle = 0;
  bit         m_start = 1'b0;
  bit         m_last = 1'b0;
  logic [7:0] m_data = '0;
  int         grant_log[$];
  logic [7:0] model_tx_log[$];
  logic [7:0] dut_tx_log[$];

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy),
    .grant     (grant),
    .active    (active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @%0t: got %0h, want %0h", name, $time, act, exp);
    end
  endtask

  task automatic release_owner();
    m_ptr   = (m_owner + 1) % NUM_REQ;
    m_owner = -1;
    m_open  = 1'b0;
    m_phase = 0;
  endtask

  // Reference model, advanced on each rising edge from the inputs seen during the cycle.
  always @(posedge clk) begin
    m_start = 1'b0;
    if (rst) begin
      m_on = 1'b1; m_owner = -1; m_ptr = 0; m_open = 1'b0; m_phase = 0;
      m_idle = 0; m_last = 1'b0; m_data = '0;
    end else if (m_owner < 0) begin
      if (req_valid != '0 && !tx_busy) begin
        for (int k = 0; k < NUM_REQ; k++)
          if (m_owner < 0 && req_valid[(m_ptr + k) % NUM_REQ]) m_owner = (m_ptr + k) % NUM_REQ;
        m_open = 1'b1;
        m_idle = 0;
        grant_log.push_back(m_owner);
      end
    end else if (m_open) begin
      if (req_valid[m_owner]) begin
        m_open  = 1'b0;
        m_start = 1'b1;
        m_data  = req_data[8*m_owner +: 8];
        m_last  = req_last[m_owner];
        m_phase = 1;
        model_tx_log.push_back(m_data);
      end else begin
        m_idle++;
        if (TMO_EN && m_idle >= TIMEOUT) release_owner();
      end
    end else if (m_phase == 1) begin
      if (tx_busy) m_phase = 2;
    end else if (!tx_busy) begin
      if (m_last) release_owner();
      else begin
        m_open = 1'b1;
        m_idle = 0;
      end
    end
  end

  // Compare every DUT output against the model away from the active edge.
  always @(negedge clk) begin : cmp
    logic [NUM_REQ-1:0] eg;
    logic [NUM_REQ-1:0] er;
    if (m_on) begin
      eg = (m_owner < 0) ? '0 : (NUM_REQ'(1) << m_owner);
      er = (!rst && m_owner >= 0 && m_open) ? (req_valid & eg) : '0;
      chk("grant", grant, eg);
      chk("active", active, (m_owner >= 0));
      chk("req_ready", req_ready, er);
      chk("tx_start", tx_start, m_start);
      chk("tx_data", tx_data, m_data);
      if (tx_start) dut_tx_log.push_back(tx_data);
    end
  end

  task automatic present(input int i, input logic [7:0] d, input logic l);
    req_valid[i]       = 1'b1;
    req_data[8*i +: 8] = d;
    req_last[i]        = l;
  endtask

  // One clock: note accepts, advance the bench transmitter, consume accepted bytes, add random traffic.
  task automatic step();
    @(negedge clk);
    acc = req_ready;
    @(posedge clk);
    #1;
    if (xmit_en) begin
      if (launch_seen) begin
        tx_busy     = 1'b1;
        busy_left   = rand_en ? int'($urandom_range(1, 6)) : busy_len;
        launch_seen = 1'b0;
      end else if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) tx_busy = 1'b0;
      end
      if (tx_start) launch_seen = 1'b1;
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (acc[i]) req_valid[i] = 1'b0;
      if (rand_en && !req_valid[i] && $urandom_range(0, 3) == 0)
        present(i, 8'($urandom), $urandom_range(0, 2) == 0);
    end
  endtask

  task automatic wait_accept(input int i, input int budget, input string name);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!acc[i] && n < budget);
    chk(name, acc[i], 1);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while ((active || tx_busy || launch_seen) && n < budget);
    chk(name, {30'd0, active, tx_busy}, 0);
  endtask

  initial begin
    // reset state, with a request already pending
    repeat (3) step();
    present(0, 8'h41, 1'b0);
    step();
    chk("rst_grant", grant, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_active", active, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_req_ready", req_ready, 0);

    // three-byte packet from requester 0 with a 160-cycle transmitter
    grant_log.delete(); dut_tx_log.delete();
    rst = 1'b0;
    wait_accept(0, 50, "t1_acc0");
    present(0, 8'h42, 1'b0);
    wait_accept(0, 400, "t1_acc1");
    present(0, 8'h43, 1'b1);
    wait_accept(0, 400, "t1_acc2");
    wait_idle(400, "t1_idle");
    chk("t1_npulses", dut_tx_log.size(), 3);
    chk("t1_byte0", dut_tx_log[0], 8'h41);
    chk("t1_byte1", dut_tx_log[1], 8'h42);
    chk("t1_byte2", dut_tx_log[2], 8'h43);
    chk("t1_ngrants", grant_log.size(), 1);
    chk("t1_owner", grant_log[0], 0);
    chk("t1_model_ptr", m_ptr, 1);

    // requesters 0 and 2 both valid at reset release
    busy_len = 10;
    rst = 1'b1;
    present(0, 8'h50, 1'b1);
    present(2, 8'h52, 1'b1);
    repeat (2) step();
    grant_log.delete();
    rst = 1'b0;
    wait_accept(0, 50, "t2_acc0");
    wait_accept(2, 100, "t2_acc2");
    wait_idle(100, "t2_idle");
    chk("t2_first", grant_log[0], 0);
    chk("t2_second", grant_log[1], 2);
    chk("t2_model_ptr", m_ptr, 3);
    chk("t2_dut_ptr", dut.rr_ptr_q, 3);

    // requester 3 single byte, then 0 and 3 together: pointer wrapped to 0
    present(3, 8'h33, 1'b1);
    wait_accept(3, 50, "t3_acc3");
    wait_idle(100, "t3_idle3");
    grant_log.delete();
    present(0, 8'h30, 1'b1);
    present(3, 8'h3a, 1'b1);
    wait_accept(0, 50, "t3_acc0");
    chk("t3_first", grant_log[0], 0);
    wait_accept(3, 100, "t3_acc3b");
    wait_idle(100, "t3_idle");

    // transmitter busy blocks the grant
    xmit_en = 1'b0;
    tx_busy = 1'b1;
    present(1, 8'h11, 1'b1);
    repeat (10) begin
      step();
      chk("t5_hold", grant, 0);
    end
    tx_busy = 1'b0;
    step();
    chk("t5_grant", grant, 4'b0010);
    xmit_en = 1'b1;
    wait_accept(1, 50, "t5_acc1");
    wait_idle(100, "t5_idle");

    // requester 1 stalls mid-packet while requester 2 waits
    grant_log.delete();
    present(1, 8'h21, 1'b0);
    wait_accept(1, 50, "t4_acc1");
    present(2, 8'h22, 1'b1);
    chk("t4_owner1", grant_log[0], 1);
`ifdef UART_ARB_TIMEOUT_EN
    wait_accept(2, 1000, "t4_tmo_acc2");
    chk("t4_release_to2", grant_log[1], 2);
    wait_idle(200, "t4_idle");
`else
    repeat (1000) step();
    chk("t4_lock_grant", grant, 4'b0010);
    chk("t4_lock_ngrants", grant_log.size(), 1);
    present(1, 8'h23, 1'b1);
    wait_accept(1, 100, "t4_acc1_last");
    wait_accept(2, 100, "t4_acc2");
    chk("t4_then2", grant_log[1], 2);
    wait_idle(200, "t4_idle");
`endif

    // reset while waiting for the transmitter to finish
    busy_len = 30;
    present(0, 8'h5a, 1'b1);
    wait_accept(0, 50, "t6_acc0");
    repeat (4) step();
    chk("t6_in_flight", active, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_grant", grant, 0);
    chk("t6_tx_start", tx_start, 0);
    chk("t6_active", active, 0);
    chk("t6_tx_data", tx_data, 0);
    chk("t6_req_ready", req_ready, 0);
    grant_log.delete();
    present(3, 8'h6b, 1'b1);
    wait_accept(3, 200, "t6_acc3");
    chk("t6_owner3", grant_log[0], 3);
    wait_idle(200, "t6_idle");

    // randomized traffic checked cycle by cycle against the model
    model_tx_log.delete(); dut_tx_log.delete();
    rand_en = 1'b1;
    repeat (3000) step();
    rand_en = 1'b0;
    begin
      int n;
      n = 0;
      while ((active || req_valid != '0 || tx_busy || launch_seen) && n < 3000) begin
        for (int i = 0; i < NUM_REQ; i++)
          if (grant[i] && !req_valid[i] && !req_last[i]) present(i, 8'($urandom), 1'b1);
        step();
        n++;
      end
      chk("rand_drain", {30'd0, active, tx_busy}, 0);
    end
    chk("rand_nbytes", dut_tx_log.size(), model_tx_log.size());
    chk("rand_activity", dut_tx_log.size() > 20, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
